btb_update_arbiter: RTL and testbench

Sequences branch-predictor update traffic into the BTB's single `operate_*` port. Two requesters share the port. The decode stage issues RAS push/pop and entry-add requests, and it can stall. The execute stage issues resolved-branch feedback (direction, target, mispredict), and it cannot stall, so its requests are buffered in a small FIFO. The block sits between ID/EX and the BTB, and its output is registered so the BTB sees at most one operation per cycle.

---
 rtl/btb_pkg.sv | 31 +++
 rtl/btb_upd_fifo.sv | 68 ++++++
 rtl/btb_update_arbiter.sv | 167 ++++++++++++++++
 tb/tb_btb_update_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
// Shared types and constants for the branch-predictor update path.
//   btb_op_e   : BTB operation requested by decode or execute
//   btb_upd_t  : one update request (operation, RAS flags, operands)
// ---------------------------------------------------------------------------
package btb_pkg;

    localparam int BTB_IDX_W = 5;
    localparam int RAS_DEPTH = 8;

    typedef enum logic [2:0] {
        NOP       = 3'd0,
        ADD       = 3'd1,
        DEL       = 3'd2,
        PRE_ERR   = 3'd3,
        PRE_RIGHT = 3'd4,
        TGT_ERR   = 3'd5
    } btb_op_e;

    typedef struct packed {
        btb_op_e              op;
        logic                 push_ras;
        logic                 pop_ras;
        logic [31:0]          pc;
        logic [BTB_IDX_W-1:0] index;
        logic                 orien;
        logic [31:0]          target;
    } btb_upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// ---------------------------------------------------------------------------
// btb_upd_fifo
// Synchronous FIFO without fall-through: an entry written in cycle N is first
// visible at rdata in cycle N+1. Full/empty come from the registered count, so
// a pop does not make room for a push in the same cycle while full.
//   clk, reset : clock, synchronous active-high reset (clears pointers/count)
//   push/wdata : write request; ignored while full
//   pop/rdata  : read request; ignored while empty; rdata shows the head
//   count      : occupancy, $clog2(DEPTH)+1 bits
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module btb_upd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/btb_update_arbiter.sv
// ---------------------------------------------------------------------------
// btb_update_arbiter
// Merges decode (stallable) and execute (non-stallable, FIFO-buffered) BTB
// update requests onto the single registered operate_* port.
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : kills this cycle's decode request (FIFO kept)
//   id_valid/id_ready/id_req : decode request handshake; id_ready is the
//                           combinational grant. A request transfers in a
//                           cycle where id_valid && id_ready.
//   ex_valid/ex_ready/ex_req : execute request; ex_valid && !ex_ready drops it
//   operate_en + flags    : one registered BTB operation per cycle
//   operate_pc/right_target/operate_index : operands, hold when idle
//   ex_overflow           : pulse one cycle after a dropped execute request
//   dbg_fifo_count, dbg_starve_cnt : internal state for observation
// Optional: define BTB_UPD_STATS_EN to add stat_id_grants, stat_ex_grants,
// stat_ex_drops (32-bit saturating event counters).
// ---------------------------------------------------------------------------
module btb_update_arbiter
    import btb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          id_valid,
    output logic                          id_ready,
    input  btb_upd_t                      id_req,
    input  logic                          ex_valid,
    output logic                          ex_ready,
    input  btb_upd_t                      ex_req,
    output logic                          operate_en,
    output logic [31:0]                   operate_pc,
    output logic [31:0]                   right_target,
    output logic [BTB_IDX_W-1:0]          operate_index,
    output logic                          add_entry,
    output logic                          delete_entry,
    output logic                          pre_error,
    output logic                          pre_right,
    output logic                          target_error,
    output logic                          right_orien,
    output logic                          push_ras,
    output logic                          pop_ras,
    output logic                          ex_overflow,
    output logic [$clog2(DEPTH):0]        dbg_fifo_count,
    output logic [$clog2(STARVE_MAX+1)-1:0] dbg_starve_cnt
`ifdef BTB_UPD_STATS_EN
    ,
    output logic [31:0]                   stat_id_grants,
    output logic [31:0]                   stat_ex_grants,
    output logic [31:0]                   stat_ex_drops
`endif
);

    localparam int SW = $clog2(STARVE_MAX+1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    btb_upd_t             w_fifo_head;
    logic                 w_id_live;
    logic                 w_grant_id;
    logic                 w_grant_ex;
    logic                 w_grant;
    logic                 w_ex_push;
    logic                 w_ex_drop;
    logic                 w_op_fire;
    btb_upd_t             w_sel;
    logic [SW-1:0]        r_starve_cnt;

    btb_upd_fifo #(
        .W     ($bits(btb_upd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_ex_push),
        .wdata (ex_req),
        .pop   (w_grant_ex),
        .rdata (w_fifo_head),
        .count (dbg_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Decode normally yields to queued execute feedback; it wins outright
    // when the FIFO is empty or once it has waited STARVE_MAX EX grants.
    always_comb begin
        w_id_live  = id_valid && !flush;
        w_grant_id = w_id_live && (w_fifo_empty || (r_starve_cnt == STARVE_LIM));
        w_grant_ex = !w_grant_id && !w_fifo_empty;
        w_grant    = w_grant_id || w_grant_ex;
        w_ex_push  = ex_valid && !w_fifo_full;
        w_ex_drop  = ex_valid && w_fifo_full;
        w_sel      = w_grant_id ? id_req : w_fifo_head;
        // A bare NOP still consumes its grant but produces no BTB strobe.
        w_op_fire  = w_grant &&
                     !((w_sel.op == NOP) && !w_sel.push_ras && !w_sel.pop_ras);
    end

    assign id_ready       = w_grant_id;
    assign ex_ready       = !w_fifo_full;
    assign dbg_starve_cnt = r_starve_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant_id || !id_valid) begin
            r_starve_cnt <= '0;
        end else if (w_grant_ex && w_id_live && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_ONE;
        end
    end

    // Output register: strobe and flags are rebuilt every cycle (zero when
    // nothing fires); operands load on any grant and otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            operate_en    <= 1'b0;
            add_entry     <= 1'b0;
            delete_entry  <= 1'b0;
            pre_error     <= 1'b0;
            pre_right     <= 1'b0;
            target_error  <= 1'b0;
            right_orien   <= 1'b0;
            push_ras      <= 1'b0;
            pop_ras       <= 1'b0;
            ex_overflow   <= 1'b0;
            operate_pc    <= '0;
            right_target  <= '0;
            operate_index <= '0;
        end else begin
            operate_en    <= w_op_fire;
            add_entry     <= w_op_fire && (w_sel.op == ADD);
            delete_entry  <= w_op_fire && (w_sel.op == DEL);
            pre_error     <= w_op_fire && (w_sel.op == PRE_ERR);
            pre_right     <= w_op_fire && (w_sel.op == PRE_RIGHT);
            target_error  <= w_op_fire && (w_sel.op == TGT_ERR);
            right_orien   <= w_op_fire && w_sel.orien;
            push_ras      <= w_op_fire && w_sel.push_ras;
            pop_ras       <= w_op_fire && w_sel.pop_ras;
            ex_overflow   <= w_ex_drop;
            if (w_grant) begin
                operate_pc    <= w_sel.pc;
                right_target  <= w_sel.target;
                operate_index <= w_sel.index;
            end
        end
    end

`ifdef BTB_UPD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_id_grants <= '0;
            stat_ex_grants <= '0;
            stat_ex_drops  <= '0;
        end else begin
            if (w_grant_id && (stat_id_grants != '1)) stat_id_grants <= stat_id_grants + 32'd1;
            if (w_grant_ex && (stat_ex_grants != '1)) stat_ex_grants <= stat_ex_grants + 32'd1;
            if (w_ex_drop  && (stat_ex_drops  != '1)) stat_ex_drops  <= stat_ex_drops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_update_arbiter.sv
module tb_btb_update_arbiter;
    import btb_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset, flush, id_valid, ex_valid;
    btb_upd_t    id_req, ex_req;
    logic        id_ready, ex_ready, operate_en, ex_overflow;
    logic [31:0] operate_pc, right_target;
    logic [4:0]  operate_index;
    logic        add_entry, delete_entry, pre_error, pre_right, target_error;
    logic        right_orien, push_ras, pop_ras;
    logic [2:0]  dbg_fifo_count;
    logic [1:0]  dbg_starve_cnt;

    always #5 clk = ~clk;

    btb_update_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_req(id_req),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_req(ex_req),
        .operate_en(operate_en), .operate_pc(operate_pc), .right_target(right_target),
        .operate_index(operate_index), .add_entry(add_entry), .delete_entry(delete_entry),
        .pre_error(pre_error), .pre_right(pre_right), .target_error(target_error),
        .right_orien(right_orien), .push_ras(push_ras), .pop_ras(pop_ras),
        .ex_overflow(ex_overflow), .dbg_fifo_count(dbg_fifo_count),
        .dbg_starve_cnt(dbg_starve_cnt)
    );

    logic [7:0] dut_flags;
    assign dut_flags = {add_entry, delete_entry, pre_error, pre_right, target_error,
                        right_orien, push_ras, pop_ras};

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    btb_upd_t    m_q[$];
    int          m_starve;
    bit          m_en, m_ovf;
    logic [7:0]  m_flags;
    logic [31:0] m_pc, m_tgt;
    logic [4:0]  m_idx;

    function automatic bit m_grant_id();
        return id_valid && !flush && (m_q.size() == 0 || m_starve == STARVE_MAX);
    endfunction

    function automatic bit m_ex_ready();
        return m_q.size() != DEPTH;
    endfunction

    function automatic logic [7:0] decode(btb_upd_t r);
        logic [7:0] f;
        f    = '0;
        f[7] = (r.op == ADD);
        f[6] = (r.op == DEL);
        f[5] = (r.op == PRE_ERR);
        f[4] = (r.op == PRE_RIGHT);
        f[3] = (r.op == TGT_ERR);
        f[2] = r.orien;
        f[1] = r.push_ras;
        f[0] = r.pop_ras;
        return f;
    endfunction

    function automatic btb_upd_t mk(btb_op_e op, logic [31:0] pc);
        btb_upd_t r;
        r        = '0;
        r.op     = op;
        r.pc     = pc;
        r.index  = pc[6:2];
        r.target = pc + 32'h40;
        return r;
    endfunction

    function automatic btb_upd_t rand_req();
        btb_upd_t r;
        r.op       = btb_op_e'($urandom_range(0, 5));
        r.push_ras = 1'($urandom_range(0, 1));
        r.pop_ras  = 1'($urandom_range(0, 1));
        r.pc       = $urandom;
        r.index    = 5'($urandom_range(0, 31));
        r.orien    = 1'($urandom_range(0, 1));
        r.target   = $urandom;
        return r;
    endfunction

    // Advance one clock: the model decides from the inputs present before the
    // edge, then commits after it. Returns #1 after the edge.
    task automatic tick();
        bit gid, gex, full, fire, in_rst, in_exv, in_idv, live;
        btb_upd_t sel, in_ex;
        int ns;
        in_rst = reset;
        in_exv = ex_valid;
        in_ex  = ex_req;
        in_idv = id_valid;
        live   = id_valid && !flush;
        gid    = m_grant_id();
        full   = !m_ex_ready();
        gex    = !gid && (m_q.size() != 0);
        sel    = gid ? id_req : (gex ? m_q[0] : '0);
        fire   = (gid || gex) && !(sel.op == NOP && !sel.push_ras && !sel.pop_ras);
        ns     = m_starve;
        if (gid || !in_idv) ns = 0;
        else if (gex && live) ns = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
        @(posedge clk);
        if (in_rst) begin
            m_q.delete();
            m_starve = 0; m_en = 0; m_ovf = 0; m_flags = '0;
            m_pc = '0; m_tgt = '0; m_idx = '0;
        end else begin
            m_en    = fire;
            m_flags = fire ? decode(sel) : 8'h00;
            if (gid || gex) begin
                m_pc = sel.pc; m_tgt = sel.target; m_idx = sel.index;
            end
            m_ovf = in_exv && full;
            if (gex) void'(m_q.pop_front());
            if (in_exv && !full) m_q.push_back(in_ex);
            m_starve = ns;
        end
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; id_valid = 0; ex_valid = 0; id_req = '0; ex_req = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        checks++; if (operate_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", operate_en); end
        checks++; if (dut_flags !== 8'h00) begin errors++; $display("FAIL reset_flags got %h exp 00", dut_flags); end
        checks++; if (ex_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ex_overflow); end
        checks++; if (operate_pc !== 32'h0 || right_target !== 32'h0 || operate_index !== 5'h0) begin
            errors++; $display("FAIL reset_operands got %h/%h/%h exp 0", operate_pc, right_target, operate_index); end
        checks++; if (dbg_fifo_count !== 3'd0 || dbg_starve_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_state got cnt %0d starve %0d exp 0/0", dbg_fifo_count, dbg_starve_cnt); end
        checks++; if (ex_ready !== 1'b1 || id_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got ex %b id %b exp 1/0", ex_ready, id_ready); end
    endtask

    task automatic test_id_add();
        btb_upd_t r;
        r = mk(ADD, 32'h1C00_0010);
        r.index = 5'd3;
        id_valid = 1; id_req = r;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL id_add_ready got %b exp 1", id_ready); end
        tick();
        id_valid = 0;
        checks++; if (operate_en !== 1'b1) begin errors++; $display("FAIL id_add_en got %b exp 1", operate_en); end
        checks++; if (dut_flags !== 8'h80) begin errors++; $display("FAIL id_add_flags got %h exp 80", dut_flags); end
        checks++; if (operate_pc !== 32'h1C00_0010 || operate_index !== 5'd3) begin
            errors++; $display("FAIL id_add_operands got pc %h idx %0d exp 1c000010/3", operate_pc, operate_index); end
        tick();
        checks++; if (operate_en !== 1'b0 || dut_flags !== 8'h00) begin
            errors++; $display("FAIL id_add_idle got en %b flags %h exp 0/00", operate_en, dut_flags); end
        checks++; if (operate_pc !== 32'h1C00_0010) begin errors++; $display("FAIL id_add_hold got %h exp 1c000010", operate_pc); end
    endtask

    task automatic test_ex_stream();
        bit exp_en;
        for (int c = 0; c < 7; c++) begin
            ex_valid = (c < 4);
            ex_req   = mk(PRE_ERR, 32'h1000_0000 + 32'(c * 4));
            tick();
            exp_en = (c >= 1 && c <= 4);
            checks++; if (operate_en !== exp_en) begin
                errors++; $display("FAIL ex_stream_en c%0d got %b exp %b", c, operate_en, exp_en); end
            if (exp_en) begin
                checks++; if (operate_pc !== 32'h1000_0000 + 32'((c - 1) * 4) || pre_error !== 1'b1) begin
                    errors++; $display("FAIL ex_stream_op c%0d got pc %h pe %b exp %h/1", c, operate_pc,
                                       pre_error, 32'h1000_0000 + 32'((c - 1) * 4)); end
            end
            checks++; if (ex_overflow !== 1'b0) begin errors++; $display("FAIL ex_stream_ovf c%0d got %b exp 0", c, ex_overflow); end
        end
        ex_valid = 0;
    endtask

    task automatic test_flush();
        id_valid = 1; flush = 1; id_req = mk(ADD, 32'h1C00_0100);
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", id_ready); end
        tick();
        checks++; if (operate_en !== 1'b0) begin errors++; $display("FAIL flush_noop got %b exp 0", operate_en); end
        flush = 0;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_retry_ready got %b exp 1", id_ready); end
        tick();
        id_valid = 0;
        checks++; if (operate_en !== 1'b1 || add_entry !== 1'b1 || operate_pc !== 32'h1C00_0100) begin
            errors++; $display("FAIL flush_retry_op got en %b add %b pc %h exp 1/1/1c000100", operate_en, add_entry, operate_pc); end
    endtask

    // ID held valid while EX pushes every cycle: pattern ID,EX,EX,EX,ID,...
    // leaks one entry per round until the FIFO fills and a request drops.
    task automatic test_overflow_starve();
        byte seq[$];
        int  ovf_cnt = 0, k_id = 0, k_ex = 0;
        bit  dropped = 0;
        id_valid = 1; id_req = mk(ADD, 32'h2000_0000);
        for (int cyc = 0; cyc < 40 && !dropped; cyc++) begin
            ex_valid = 1;
            ex_req   = mk(PRE_RIGHT, 32'h3000_0000 + 32'(k_ex * 4));
            #1;
            if (!ex_ready) dropped = 1; else k_ex++;
            if (id_ready) begin
                tick();
                k_id++;
                id_req = mk(ADD, 32'h2000_0000 + 32'(k_id * 4));
            end else tick();
            if (operate_en) seq.push_back(add_entry ? "I" : (pre_right ? "E" : "?"));
            if (ex_overflow) ovf_cnt++;
        end
        ex_valid = 0; id_valid = 0;
        checks++; if (!dropped) begin errors++; $display("FAIL ovf_drop_seen got 0 exp 1"); end
        checks++; if (ex_overflow !== 1'b1 || ovf_cnt != 1) begin
            errors++; $display("FAIL ovf_pulse got now %b count %0d exp 1/1", ex_overflow, ovf_cnt); end
        checks++; if (seq.size() < 5 || seq[0] != "I" || seq[1] != "E" || seq[2] != "E" || seq[3] != "E" || seq[4] != "I") begin
            errors++; $display("FAIL starve_pattern got size %0d exp I,E,E,E,I", seq.size()); end
        checks++; if (dbg_fifo_count !== 3'd3) begin errors++; $display("FAIL ovf_count got %0d exp 3", dbg_fifo_count); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        checks++; if (operate_en !== 1'b0 || dbg_fifo_count !== 3'd0) begin
            errors++; $display("FAIL rst_mid_state got en %b cnt %0d exp 0/0", operate_en, dbg_fifo_count); end
        #1;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", ex_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (operate_en !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet i%0d got %b exp 0", i, operate_en); end
        end
        ex_valid = 1; ex_req = mk(TGT_ERR, 32'h4000_0020);
        tick();
        ex_valid = 0;
        checks++; if (operate_en !== 1'b0) begin errors++; $display("FAIL rst_mid_lat1 got %b exp 0", operate_en); end
        tick();
        checks++; if (operate_en !== 1'b1 || target_error !== 1'b1 || operate_pc !== 32'h4000_0020) begin
            errors++; $display("FAIL rst_mid_lat2 got en %b te %b pc %h exp 1/1/40000020", operate_en, target_error, operate_pc); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset    = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 1) == 1);
            ex_valid = ($urandom_range(0, 9) < 6);
            id_req   = rand_req();
            ex_req   = rand_req();
            #1;
            checks++; if (id_ready !== m_grant_id() || ex_ready !== m_ex_ready()) begin
                errors++; $display("FAIL rnd_ready c%0d got id %b ex %b exp %b/%b", cyc, id_ready, ex_ready,
                                   m_grant_id(), m_ex_ready()); end
            tick();
            checks++; if (operate_en !== m_en || dut_flags !== m_flags || ex_overflow !== m_ovf) begin
                errors++; $display("FAIL rnd_out c%0d got en %b fl %h ovf %b exp %b/%h/%b", cyc, operate_en,
                                   dut_flags, ex_overflow, m_en, m_flags, m_ovf); end
            checks++; if (operate_pc !== m_pc || right_target !== m_tgt || operate_index !== m_idx) begin
                errors++; $display("FAIL rnd_operands c%0d got %h/%h/%h exp %h/%h/%h", cyc, operate_pc,
                                   right_target, operate_index, m_pc, m_tgt, m_idx); end
            checks++; if (int'(dbg_fifo_count) != m_q.size() || int'(dbg_starve_cnt) != m_starve) begin
                errors++; $display("FAIL rnd_state c%0d got cnt %0d starve %0d exp %0d/%0d", cyc,
                                   dbg_fifo_count, dbg_starve_cnt, m_q.size(), m_starve); end
        end
        idle_inputs();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_id_add();
        test_ex_stream();
        test_flush();
        test_overflow_starve();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
